// File: rtl/alu_64_pkg.sv
// Shared ALU definitions: data width and alu_fun encodings.
// The execute stage maps OPq ifun 0..3 straight onto alu_fun_e.
package alu_64_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned FUN_W  = 2;

  typedef enum logic [FUN_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_fun_e;

  // Registered ALU result bundle.
  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              overflow;
  } alu_result_t;

  // True for the operations that go through the adder/subtractor.
  function automatic logic is_arith(input alu_fun_e fun);
    return (fun == ALU_ADD) || (fun == ALU_SUB);
  endfunction

endpackage : alu_64_pkg

// File: rtl/add_sub_64.sv
// 64-bit ripple-carry adder/subtractor built from full-adder cells.
// Subtract is a + ~b + 1: b inverted and carry-in driven by sub.
module add_sub_64
  import alu_64_pkg::*;
(
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum_c,
  output logic              overflow_c
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] carry;

  assign b_eff    = b ^ {DATA_W{sub}};
  assign carry[0] = sub;

  // Full-adder chain; the carry out of the top cell is intentionally dropped.
  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    assign sum_c[i] = a[i] ^ b_eff[i] ^ carry[i];
    if (i < DATA_W - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

  // Effective operands share a sign but the result sign differs. With b_eff
  // inverted for subtract this covers both add and subtract overflow rules.
  assign overflow_c = (a[DATA_W-1] == b_eff[DATA_W-1]) &&
                      (sum_c[DATA_W-1] != a[DATA_W-1]);

endmodule : add_sub_64

// File: rtl/alu_64.sv
// 64-bit execute-stage ALU: add, subtract, AND, XOR with signed overflow.
// Single-cycle latency; result and overflow are registered every cycle.
module alu_64
  import alu_64_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [FUN_W-1:0]  alu_fun,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] valE,
  output logic              overflow
);

  alu_fun_e          fun;
  logic [DATA_W-1:0] arith_sum;
  logic              arith_ovf;
  alu_result_t       result_c;
  alu_result_t       result_q;

  assign fun = alu_fun_e'(alu_fun);

  add_sub_64 u_add_sub (
    .sub        (fun == ALU_SUB),
    .a          (A),
    .b          (B),
    .sum_c      (arith_sum),
    .overflow_c (arith_ovf)
  );

  // Result select; logic ops never report overflow.
  always_comb begin
    result_c.val      = '0;
    result_c.overflow = 1'b0;
    unique case (fun)
      ALU_ADD, ALU_SUB: begin
        result_c.val      = arith_sum;
        result_c.overflow = arith_ovf & is_arith(fun);
      end
      ALU_AND: result_c.val = A & B;
      ALU_XOR: result_c.val = A ^ B;
      default: begin
        result_c.val      = '0;
        result_c.overflow = 1'b0;
      end
    endcase
  end

  // Output register; reset wins over the incoming operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_c;
    end
  end

  assign valE     = result_q.val;
  assign overflow = result_q.overflow;

endmodule : alu_64

// File: tb/tb_alu_64.sv
// Directed self-checking bench for alu_64.
module tb_alu_64;
  import alu_64_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  alu_fun;
  logic [63:0] A;
  logic [63:0] B;
  logic [63:0] valE;
  logic        overflow;

  int checks;
  int failures;

  alu_64 dut (
    .clk      (clk),
    .reset    (reset),
    .alu_fun  (alu_fun),
    .A        (A),
    .B        (B),
    .valE     (valE),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    reset   = 1'b1;
    alu_fun = 2'b00;
    A       = 64'h7FFF_FFFF_FFFF_FFFF;
    B       = 64'h1;
    @(posedge clk); #1;
    checks++;
    if (valE !== 64'h0) begin
      failures++;
      $display("FAIL reset_valE got=%h exp=%h", valE, 64'h0);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b exp=%b", overflow, 1'b0);
    end
    // Release reset with a real add on the bus: first result one edge later.
    @(negedge clk);
    reset   = 1'b0;
    alu_fun = 2'b00;
    A       = 64'd5;
    B       = 64'd7;
    #1;
    checks++;
    if (valE !== 64'h0) begin
      failures++;
      $display("FAIL reset_hold_before_edge got=%h exp=%h", valE, 64'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (valE !== 64'd12 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL first_after_reset got=%h/%b exp=%h/%b", valE, overflow, 64'd12, 1'b0);
    end
  endtask

  task automatic test_add();
    logic [63:0] a [4];
    logic [63:0] b [4];
    logic [63:0] e [4];
    logic        o [4];
    a[0] = 64'd5;                  b[0] = 64'd7;  e[0] = 64'd12;                 o[0] = 1'b0;
    a[1] = 64'h7FFF_FFFF_FFFF_FFFF; b[1] = 64'd1;  e[1] = 64'h8000_0000_0000_0000; o[1] = 1'b1;
    a[2] = 64'hFFFF_FFFF_FFFF_FFFF; b[2] = 64'd1;  e[2] = 64'h0;                   o[2] = 1'b0;
    a[3] = 64'h8000_0000_0000_0000; b[3] = 64'h8000_0000_0000_0000; e[3] = 64'h0; o[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_fun = 2'b00; A = a[i]; B = b[i];
      @(posedge clk); #1;
      checks++;
      if (valE !== e[i] || overflow !== o[i]) begin
        failures++;
        $display("FAIL add[%0d] got=%h/%b exp=%h/%b", i, valE, overflow, e[i], o[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [63:0] a [4];
    logic [63:0] b [4];
    logic [63:0] e [4];
    logic        o [4];
    a[0] = 64'd3;                  b[0] = 64'd10; e[0] = 64'hFFFF_FFFF_FFFF_FFF9; o[0] = 1'b0;
    a[1] = 64'h8000_0000_0000_0000; b[1] = 64'd1;  e[1] = 64'h7FFF_FFFF_FFFF_FFFF; o[1] = 1'b1;
    a[2] = 64'h0; b[2] = 64'h8000_0000_0000_0000;  e[2] = 64'h8000_0000_0000_0000; o[2] = 1'b1;
    a[3] = 64'd5;                  b[3] = 64'd5;  e[3] = 64'h0;                   o[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_fun = 2'b01; A = a[i]; B = b[i];
      @(posedge clk); #1;
      checks++;
      if (valE !== e[i] || overflow !== o[i]) begin
        failures++;
        $display("FAIL sub[%0d] got=%h/%b exp=%h/%b", i, valE, overflow, e[i], o[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [1:0]  f [4];
    logic [63:0] a [4];
    logic [63:0] b [4];
    logic [63:0] e [4];
    f[0] = 2'b10; a[0] = 64'hF0F0; b[0] = 64'hFF00; e[0] = 64'hF000;
    f[1] = 2'b11; a[1] = 64'hF0F0; b[1] = 64'hFF00; e[1] = 64'h0FF0;
    // Operands that would overflow an add must not raise overflow here.
    f[2] = 2'b10; a[2] = 64'h7FFF_FFFF_FFFF_FFFF; b[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    e[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    f[3] = 2'b11; a[3] = 64'h7FFF_FFFF_FFFF_FFFF; b[3] = 64'h8000_0000_0000_0001;
    e[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_fun = f[i]; A = a[i]; B = b[i];
      @(posedge clk); #1;
      checks++;
      if (valE !== e[i] || overflow !== 1'b0) begin
        failures++;
        $display("FAIL logic[%0d] got=%h/%b exp=%h/%b", i, valE, overflow, e[i], 1'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  f [4];
    logic [63:0] a [4];
    logic [63:0] b [4];
    logic [63:0] e [4];
    logic        o [4];
    logic [63:0] prev_e;
    logic        prev_o;
    f[0] = 2'b00; a[0] = 64'h7FFF_FFFF_FFFF_FFFF; b[0] = 64'd1;
    e[0] = 64'h8000_0000_0000_0000; o[0] = 1'b1;
    f[1] = 2'b01; a[1] = 64'd3;   b[1] = 64'd10;  e[1] = 64'hFFFF_FFFF_FFFF_FFF9; o[1] = 1'b0;
    f[2] = 2'b10; a[2] = 64'hF0F0; b[2] = 64'hFF00; e[2] = 64'hF000; o[2] = 1'b0;
    f[3] = 2'b11; a[3] = 64'hF0F0; b[3] = 64'hFF00; e[3] = 64'h0FF0; o[3] = 1'b0;
    prev_e = 64'hFFFF_FFFF_FFFF_FFFE;   // last result of test_logic
    prev_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_fun = f[i]; A = a[i]; B = b[i];
      #1;
      checks++;
      if (valE !== prev_e || overflow !== prev_o) begin
        failures++;
        $display("FAIL b2b_hold[%0d] got=%h/%b exp=%h/%b", i, valE, overflow, prev_e, prev_o);
      end
      @(posedge clk); #1;
      checks++;
      if (valE !== e[i] || overflow !== o[i]) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h/%b exp=%h/%b", i, valE, overflow, e[i], o[i]);
      end
      prev_e = e[i];
      prev_o = o[i];
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    alu_fun = 2'b01; A = 64'h8000_0000_0000_0000; B = 64'd1;
    @(posedge clk); #1;
    checks++;
    if (valE !== 64'h7FFF_FFFF_FFFF_FFFF || overflow !== 1'b1) begin
      failures++;
      $display("FAIL pre_mid_reset got=%h/%b exp=%h/%b", valE, overflow, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    end
    @(negedge clk);
    reset = 1'b1; alu_fun = 2'b00; A = 64'h7FFF_FFFF_FFFF_FFFF; B = 64'd1;
    @(posedge clk); #1;
    checks++;
    if (valE !== 64'h0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%h/%b exp=%h/%b", valE, overflow, 64'h0, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0; alu_fun = 2'b11; A = 64'hAAAA_5555_0000_FFFF; B = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    checks++;
    if (valE !== 64'h5555_AAAA_FFFF_0000 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL after_mid_reset got=%h/%b exp=%h/%b", valE, overflow, 64'h5555_AAAA_FFFF_0000, 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    alu_fun  = 2'b00;
    A        = '0;
    B        = '0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_64
